rr_sel_arbiter: RTL
===================

Name: rr_sel_arbiter

Overview:
- Upstream control stage for the registered N-input mux.
- Watches the per-input valid vector and arbitrates round-robin among active inputs.
- Drives the mux `sel` and a qualifying `sel_v`.
- Holds each grant for a bounded burst of accepted beats, so one input cannot starve the others.

Parameters:
- NUMIN, 16, number of requesters; must match the mux NUMIN; must be >= 2.
- SWIDTH, $clog2(NUMIN), width of sel.
- MAXBURST, 4, maximum accepted beats per grant; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- req  input  NUMIN  per-input valid; connects to the same vector as the mux din_vec_v.
- ack  input  1  downstream accepted the current beat this cycle.
- sel  output  SWIDTH  registered index of the granted input; drives the mux sel.
- sel_v  output  1  registered; 1 while a grant is active.
- grant  output  NUMIN  registered one-hot of sel, qualified by sel_v; all zeros when idle.
- beat_cnt  output  $clog2(MAXBURST+1)  registered count of accepted beats in the current grant.

Behaviour:
- Reset: while rst=0, asynchronously force the following, independent of clk:
  - sel=0, sel_v=0, grant=0, beat_cnt=0
  - state=IDLE, internal round-robin pointer ptr=0
- Reset mid-burst: abandon the burst; the first grant after release searches from ptr=0.
- States: IDLE and GRANT.
- Winner search:
  - Search starts at ptr and moves upward.
  - From NUMIN-1 it wraps to 0; use an explicit compare, not power-of-2 masking, so non-power-of-2 NUMIN works.
  - The first set req bit wins.
- IDLE:
  - If req≠0, load the winner into sel, set sel_v=1 and grant=one-hot(winner), clear beat_cnt, and go to GRANT. All of this is visible on the next edge: 1-cycle latency from req to sel_v.
  - If req=0, stay in IDLE with outputs unchanged (sel keeps its last value, sel_v=0).
- GRANT, accepted beat: a cycle with ack=1 and req[sel]=1 counts one beat; beat_cnt increments.
- GRANT, release: the grant is released when either condition holds:
  - the beat just accepted makes beat_cnt reach MAXBURST, or
  - req[sel]=0 (requester dropped, with or without ack).
- On release, set ptr = sel+1 (wrapping NUMIN-1 to 0), then re-arbitrate in the same cycle from the new ptr against the current req:
  - Winner found: load the new sel and grant, clear beat_cnt, stay in GRANT. sel_v stays 1, with no bubble.
  - Winner may be the same index if it is the only requester; it then starts a fresh burst.
  - No winner: go to IDLE with sel_v=0, grant=0, beat_cnt=0.
- ack=0 with req[sel]=1: hold sel and beat_cnt indefinitely; there is no timeout.
- ack=1 while in IDLE: ignored.
- Simultaneous events:
  - A new req bit rising in the release cycle takes part in that cycle's arbitration.
  - A req bit rising mid-burst waits for release.
- beat_cnt never exceeds MAXBURST; it saturates by construction because release clears it.

Optional Feature:
- Macro: RR_SEL_ARBITER_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - While in GRANT with lock=1, the MAXBURST release condition is suppressed. beat_cnt holds at MAXBURST and does not wrap.
  - Release then happens only when req[sel]=0, or on the first accepted beat with lock=0 and beat_cnt=MAXBURST.
  - A requester drop still releases even when lock=1.
- Not defined: no `lock` port; behaviour exactly as in Behaviour.

Test Plan:
- rst driven 0 mid-burst between clock edges -> sel=0, sel_v=0, grant=0, beat_cnt=0 immediately; after release, req=16'h0010 -> sel=4 one cycle later.
- MAXBURST=4, req=16'h0001 held, ack=1 -> sel=0, sel_v=1 continuously; beat_cnt goes 0,1,2,3,0 repeating; sel_v never drops.
- req=16'h8001, ack=1 from reset -> sel=0 for 4 beats, then 15 for 4 beats, then 0 for 4 beats, with no idle cycles between grants.
- Grant at sel=3, ack=0 for 20 cycles -> sel=3, beat_cnt frozen, grant=16'h0008 throughout.
- sel=2 after 2 beats, req[2] dropped with req=16'h0020 -> next edge sel=5, beat_cnt=0, sel_v=1.
- Last grant at sel=15 released, req=16'h0003 -> sel=0 (wrap); with lock=1 (macro defined) and ack=1 -> sel stays 0 past 4 beats until lock=0.

Source files
------------

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the registered N-input mux select with bounded bursts.
// Optional `RR_SEL_ARBITER_LOCK_EN adds a `lock` input that extends a burst past MAXBURST.
module rr_sel_arbiter #(
  parameter int unsigned NUMIN    = 16,
  parameter int unsigned SWIDTH   = $clog2(NUMIN),
  parameter int unsigned MAXBURST = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUMIN-1:0]                 req,
  input  logic                             ack,
`ifdef RR_SEL_ARBITER_LOCK_EN
  input  logic                             lock,
`endif
  output logic [SWIDTH-1:0]                sel,
  output logic                             sel_v,
  output logic [NUMIN-1:0]                 grant,
  output logic [$clog2(MAXBURST+1)-1:0]    beat_cnt
);

  localparam int unsigned CW = $clog2(MAXBURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SWIDTH-1:0] ptr_q, ptr_d;
  logic [SWIDTH-1:0] sel_q, sel_d;
  logic              sel_v_q, sel_v_d;
  logic [NUMIN-1:0]  grant_q, grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              lock_c;
  logic [SWIDTH-1:0] next_ptr_c;
  logic [SWIDTH-1:0] start_c;
  logic [SWIDTH-1:0] win_c;
  logic              found_c;
  logic              req_sel_c;
  logic              beat_c;
  logic              at_max_c;
  logic              hit_max_c;
  logic              release_c;

`ifdef RR_SEL_ARBITER_LOCK_EN
  assign lock_c = lock;
`else
  assign lock_c = 1'b0;
`endif

  assign req_sel_c  = req[sel_q];
  assign beat_c     = ack & req_sel_c;
  assign at_max_c   = (cnt_q == CW'(MAXBURST));
  assign hit_max_c  = (cnt_q == CW'(MAXBURST - 1));
  // at_max_c is only reachable while a lock held the burst open
  assign release_c  = !req_sel_c || (beat_c && !lock_c && (hit_max_c || at_max_c));
  assign next_ptr_c = (sel_q == SWIDTH'(NUMIN - 1)) ? '0 : sel_q + SWIDTH'(1);
  assign start_c    = (state_q == GRANT) ? next_ptr_c : ptr_q;

  // First set req bit at or above start_c, wrapping by compare so any NUMIN works
  always_comb begin : rr_search
    int                idx;
    logic [SWIDTH-1:0] idx_s;
    idx     = 0;
    idx_s   = '0;
    found_c = 1'b0;
    win_c   = '0;
    for (int i = 0; i < int'(NUMIN); i++) begin
      idx = int'(start_c) + i;
      if (idx >= int'(NUMIN)) begin
        idx = idx - int'(NUMIN);
      end
      idx_s = SWIDTH'(idx);
      if (!found_c && req[idx_s]) begin
        found_c = 1'b1;
        win_c   = idx_s;
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    sel_v_d = sel_v_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = GRANT;
          sel_d   = win_c;
          sel_v_d = 1'b1;
          grant_d = NUMIN'(1) << win_c;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d = next_ptr_c;
          if (found_c) begin
            sel_d   = win_c;
            grant_d = NUMIN'(1) << win_c;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            sel_v_d = 1'b0;
            grant_d = '0;
            cnt_d   = '0;
          end
        end else if (beat_c && !at_max_c) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      sel_v_q <= 1'b0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      sel_v_q <= sel_v_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel      = sel_q;
  assign sel_v    = sel_v_q;
  assign grant    = grant_q;
  assign beat_cnt = cnt_q;

endmodule
